div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// 32-bit signed/unsigned divider, restoring algorithm, one quotient bit per clock.
// Latency: 32 clocks from accept to out_valid; 1 clock for divide-by-zero and signed overflow.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no bypass.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  div_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] q;
    logic [32:0] rem;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;
    logic        fast;

    logic        is_signed_in;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        ovf;
    logic [31:0] special;

    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        sub_ok;
    logic [32:0] rem_nx;
    logic [31:0] q_nx;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        is_signed_in = ~div_op[0];
        a_neg        = is_signed_in & src1[31];
        b_neg        = is_signed_in & src2[31];
        a_mag        = a_neg ? (32'd0 - src1) : src1;
        b_mag        = b_neg ? (32'd0 - src2) : src2;
        div_zero     = (src2 == 32'd0);
        ovf          = is_signed_in && (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
        if (div_op[1])
            special = div_zero ? src1 : 32'd0;
        else
            special = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    // Partial remainder can reach 2^33-1 after the shift, so subtract at 34 bits.
    always_comb begin
        rem_sh = {rem[31:0], q[31]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs};
        sub_ok = ~diff[33];
        rem_nx = sub_ok ? diff[32:0] : rem_sh;
        q_nx   = {q[30:0], sub_ok};
        q_fin  = q_neg ? (32'd0 - q_nx) : q_nx;
        r_fin  = r_neg ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            result <= 32'd0;
            op_q   <= 2'd0;
            q      <= 32'd0;
            rem    <= 33'd0;
            dvs    <= 32'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            fast   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= div_op;
                        q     <= a_mag;
                        rem   <= 33'd0;
                        dvs   <= b_mag;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        cnt   <= 6'd0;
                        fast  <= div_zero | ovf;
                        if (div_zero | ovf)
                            result <= special;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Special cases already have their result; spend one cycle here only.
                    if (fast) begin
                        state <= DONE;
                    end else begin
                        q   <= q_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state  <= DONE;
                            result <= op_q[1] ? r_fin : q_fin;
                        end
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
